cp0_regfile: RTL
================

// Module: cp0_regfile
// PURPOSE
//  Architectural CP0 register file (BadVAddr, Count, Compare, Status, Cause, EPC) committed from WB stage.
//  Owns the values that the MEM-stage CP0 forwarding logic reads; takes mtc0 writes, exception/eret commits,
//  external interrupt lines and the Count/Compare timer. Read port and status/cause outputs show registered state only.
//  Any forwarding of same-cycle writes is done downstream.
// PARAMETERS
//  CP0_AW        5             CP0 register address width (reg number only, sel=0)
//  COUNT_DIV     2             Count increments once every COUNT_DIV cycles (1 or 2)
// PORTS
//  clk             in   1    clock; all state updates on rising edge
//  rst             in   1    asynchronous, active-high reset
//  int_i           in   6    hardware interrupt lines, level, sampled every cycle
//  we_i            in   1    mtc0 commit enable
//  waddr_i         in   AW   mtc0 destination (8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC)
//  wdata_i         in   32   mtc0 data
//  raddr_i         in   AW   mfc0 read address
//  rdata_o         out  32   combinational read of registered state; unmapped address -> 0
//  exc_valid_i     in   1    exception commit this cycle
//  exc_code_i      in   5    ExcCode for Cause[6:2]
//  exc_pc_i        in   32   PC of faulting instruction
//  exc_bd_i        in   1    faulting instruction is in a delay slot
//  exc_badvaddr_i  in   32   bad address; latched only for ExcCode 4 (AdEL) / 5 (AdES)
//  eret_i          in   1    eret commit this cycle
//  status_o        out  32   Status register
//  cause_o         out  32   Cause register
//  epc_o           out  32   EPC register
//  timer_int_o     out  1    Cause.TI
//  int_pending_o   out  1    Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0])
// BEHAVIOUR
//  Reset (async): Status=32'h0040_0000 (BEV=1), Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, tick=0.
//  Status writable bits: IM[15:8], EXL[1], IE[0]; all other bits keep reset value. Cause writable: IP[9:8] only.
//  Count: tick counter wraps mod COUNT_DIV; Count += 1 (mod 2^32) when tick wraps to 0. mtc0 Count overrides the
//   increment that cycle; tick keeps running. Count == 32'hFFFF_FFFF wraps to 0, no flag.
//  Timer: if (Count == Compare) and Compare != 0, or Compare==0 after Count wrap, set Cause.TI[30] next cycle; TI is sticky.
//   mtc0 Compare clears TI (clear wins over a same-cycle match).
//  Cause.IP[15:10] <= {int_i[5] | TI, int_i[4:0]} every cycle (one-cycle register latency); mtc0 cannot alter them.
//  Exception (exc_valid_i): if Status.EXL==0: EPC <= exc_bd_i ? exc_pc_i-4 : exc_pc_i; Cause.BD[31] <= exc_bd_i.
//   If EXL already 1, EPC and BD unchanged. Always: Status.EXL<=1, Cause.ExcCode<=exc_code_i; BadVAddr for code 4/5.
//  eret_i: Status.EXL <= 0.
//  Same-cycle priority: exc_valid_i > eret_i > we_i for Status/Cause/EPC/BadVAddr fields they touch; mtc0 to
//   Count/Compare still commits alongside an exception. exc_valid_i with eret_i: eret ignored.
//  rdata_o/status_o/cause_o never bypass same-cycle writes: new value visible the cycle after the edge.
//  Reset mid-operation: all state returns to reset values immediately; in-flight commits dropped.
// TESTING
//  1 Reset: assert rst async mid-cycle -> status_o=0x00400000, cause_o=0, epc_o=0, int_pending_o=0 before next edge.
//  2 mtc0 Status 0xFFFFFFFF -> status_o=0x0040FF03 next cycle; mtc0 Cause 0xFFFFFFFF -> cause_o=0x00000300.
//  3 mtc0 Compare=20, Count=10, COUNT_DIV=2 -> TI and cause_o[15] set ~20 cycles later, int_pending_o=1
//    if IM7=IE=1; mtc0 Compare=40 -> TI=0 next cycle.
//  4 exc_valid_i code=4, pc=0xBFC00100, bd=1, badvaddr=0x13 -> epc_o=0xBFC000FC, cause_o[31]=1, ExcCode=4,
//    EXL=1, rdata_o@8=0x13; second exception pc=0x80 -> EPC unchanged; eret_i -> EXL=0.
//  5 Same cycle exc_valid_i + eret_i + mtc0 Status=0 -> EXL=1, IE/IM unchanged;
//    int_i[2]=1 -> cause_o[12]=1 one cycle later, cleared one cycle after drop.

Source files
------------

// File: rtl/cp0_regfile.sv
// cp0_regfile: architectural CP0 state (BadVAddr, Count, Compare, Status, Cause, EPC) committed from WB.
// All outputs show registered state; same-cycle write forwarding is handled downstream.
module cp0_regfile #(
    parameter int CP0_AW    = 5,
    parameter int COUNT_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        int_i,
    input  logic              we_i,
    input  logic [CP0_AW-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [CP0_AW-1:0] raddr_i,
    output logic [31:0]       rdata_o,
    input  logic              exc_valid_i,
    input  logic [4:0]        exc_code_i,
    input  logic [31:0]       exc_pc_i,
    input  logic              exc_bd_i,
    input  logic [31:0]       exc_badvaddr_i,
    input  logic              eret_i,
    output logic [31:0]       status_o,
    output logic [31:0]       cause_o,
    output logic [31:0]       epc_o,
    output logic              timer_int_o,
    output logic              int_pending_o
);
    localparam logic [CP0_AW-1:0] A_BADV = CP0_AW'(8);
    localparam logic [CP0_AW-1:0] A_CNT  = CP0_AW'(9);
    localparam logic [CP0_AW-1:0] A_CMP  = CP0_AW'(11);
    localparam logic [CP0_AW-1:0] A_ST   = CP0_AW'(12);
    localparam logic [CP0_AW-1:0] A_CA   = CP0_AW'(13);
    localparam logic [CP0_AW-1:0] A_EPC  = CP0_AW'(14);

    logic        tick_q, tick_d, inc;
    logic [31:0] count_q, count_d, compare_q, compare_d, epc_q, epc_d, badv_q, badv_d;
    logic        wrap_q, wrap_d, ti_q, ti_d, match;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  code_q, code_d;
    logic        wr, wr_cnt, wr_cmp;

    always_comb begin
        tick_d    = (COUNT_DIV == 1) ? 1'b0 : ~tick_q;
        inc       = (COUNT_DIV == 1) || tick_q;
        wr_cnt    = we_i && waddr_i == A_CNT;
        wr_cmp    = we_i && waddr_i == A_CMP;
        // exception/eret own Status/Cause/EPC/BadVAddr this cycle; Count/Compare writes still land
        wr        = we_i && !exc_valid_i && !eret_i;
        count_d   = wr_cnt ? wdata_i : count_q + {31'b0, inc};
        wrap_d    = !wr_cnt && inc && count_q == 32'hFFFF_FFFF;
        compare_d = wr_cmp ? wdata_i : compare_q;
        match     = (compare_q != 32'd0 && count_q == compare_q) || (compare_q == 32'd0 && wrap_q);
        ti_d      = wr_cmp ? 1'b0 : ti_q | match;
        ip_hw_d   = {int_i[5] | ti_q, int_i[4:0]};
        ip_sw_d   = (wr && waddr_i == A_CA) ? wdata_i[9:8] : ip_sw_q;
        im_d      = (wr && waddr_i == A_ST) ? wdata_i[15:8] : im_q;
        ie_d      = (wr && waddr_i == A_ST) ? wdata_i[0] : ie_q;
        exl_d     = exc_valid_i ? 1'b1 : eret_i ? 1'b0 : (wr && waddr_i == A_ST) ? wdata_i[1] : exl_q;
        bd_d      = (exc_valid_i && !exl_q) ? exc_bd_i : bd_q;
        code_d    = exc_valid_i ? exc_code_i : code_q;
        epc_d     = exc_valid_i ? (exl_q ? epc_q : exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i)
                  : (wr && waddr_i == A_EPC) ? wdata_i : epc_q;
        badv_d    = exc_valid_i ? ((exc_code_i == 5'd4 || exc_code_i == 5'd5) ? exc_badvaddr_i : badv_q)
                  : (wr && waddr_i == A_BADV) ? wdata_i : badv_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q    <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
            wrap_q    <= 1'b0;
            ti_q      <= 1'b0;
            ip_hw_q   <= '0;
            ip_sw_q   <= '0;
            im_q      <= '0;
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            bd_q      <= 1'b0;
            code_q    <= '0;
            epc_q     <= '0;
            badv_q    <= '0;
        end else begin
            tick_q    <= tick_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            wrap_q    <= wrap_d;
            ti_q      <= ti_d;
            ip_hw_q   <= ip_hw_d;
            ip_sw_q   <= ip_sw_d;
            im_q      <= im_d;
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            bd_q      <= bd_d;
            code_q    <= code_d;
            epc_q     <= epc_d;
            badv_q    <= badv_d;
        end
    end

    assign status_o      = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_o       = {bd_q, ti_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, code_q, 2'b0};
    assign epc_o         = epc_q;
    assign timer_int_o   = ti_q;
    assign int_pending_o = ie_q && !exl_q && |({ip_hw_q, ip_sw_q} & im_q);
    assign rdata_o       = raddr_i == A_BADV ? badv_q
                         : raddr_i == A_CNT  ? count_q
                         : raddr_i == A_CMP  ? compare_q
                         : raddr_i == A_ST   ? status_o
                         : raddr_i == A_CA   ? cause_o
                         : raddr_i == A_EPC  ? epc_q : 32'd0;
endmodule
